// File: rtl/rs_issue_scheduler_pkg.sv
// rtl/rs_issue_scheduler_pkg.sv - shared FSM encoding and default sizing for the issue scheduler
package rs_issue_scheduler_pkg;

   localparam int RS_IDX_BITS_DEFAULT = 3;

   typedef enum logic [0:0] {
      SCHED_IDLE  = 1'b0,
      SCHED_OFFER = 1'b1
   } sched_state_e;

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - combinational pick of the oldest requester using an age matrix
module rs_age_select #(
   parameter  int IdxBits = 3,
   localparam int N       = 1 << IdxBits
) (
   input  logic [N-1:0]         req,
   input  logic [N-1:0][N-1:0]  older,
   output logic [N-1:0]         grant,
   output logic [IdxBits-1:0]   grant_idx
);

   // An entry wins when no other requester is marked older than it.
   always_comb begin
      logic blocked;
      blocked   = 1'b0;
      grant     = '0;
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < N; j++) begin
            blocked = blocked | (req[j] & older[j][i]);
         end
         grant[i] = req[i] & ~blocked;
         if (grant[i]) begin
            grant_idx = IdxBits'(i);
         end
      end
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - oldest-ready issue scheduler; RS_ISSUE_STATS_EN adds issue/stall counters
module rs_issue_scheduler
   import rs_issue_scheduler_pkg::*;
#(
   parameter int RSIdxBits        = RS_IDX_BITS_DEFAULT,
   parameter int RStationInstance = 0
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   flush_i,
   input  logic                   allocValid_i,
   input  logic [RSIdxBits-1:0]   allocIdx_i,
   input  logic [(1<<RSIdxBits)-1:0] opReady_i,
   input  logic                   fuReady_i,
   output logic                   issueValid_o,
   output logic [RSIdxBits-1:0]   issueIdx_o,
   output logic                   freeValid_o,
   output logic [RSIdxBits-1:0]   freeIdx_o,
   output logic [RSIdxBits:0]     occupancy_o,
`ifdef RS_ISSUE_STATS_EN
   output logic [31:0]            issueCount_o,
   output logic [31:0]            stallCount_o,
`endif
   output logic                   isFull_o
);

   localparam int N = 1 << RSIdxBits;

   // Station number only identifies the instance; negative numbers are meaningless.
   if (RStationInstance < 0) begin : g_bad_station
   end

   sched_state_e              state_q, state_d;
   logic                      issue_valid;
   logic                      load_offer;
   logic [N-1:0]              occupied_q, occupied_d;
   logic [N-1:0][N-1:0]       age_q, age_d;
   logic [RSIdxBits-1:0]      issue_idx_q;
   logic                      free_valid_q;
   logic [RSIdxBits-1:0]      free_idx_q;
   logic [RSIdxBits:0]        occupancy_q, occupancy_d;
   logic [N-1:0]              offered_mask, free_mask, alloc_mask, survivors, cand;
   logic [N-1:0]              sel_grant;
   logic [RSIdxBits-1:0]      sel_idx;
   logic                      handshake, alloc_ok, cand_any;

   assign offered_mask = issue_valid ? (N'(1) << issue_idx_q) : '0;
   assign cand         = occupied_q & opReady_i & ~offered_mask;
   assign handshake    = issue_valid & fuReady_i;
   assign free_mask    = offered_mask & {N{fuReady_i}};
   // A slot being released by this cycle's handshake may be reallocated at once.
   assign alloc_ok     = allocValid_i & (~occupied_q[allocIdx_i] | free_mask[allocIdx_i]);
   assign alloc_mask   = alloc_ok ? (N'(1) << allocIdx_i) : '0;
   assign survivors    = occupied_q & ~free_mask;
   assign occupied_d   = survivors | alloc_mask;
   assign occupancy_d  = occupancy_q + (RSIdxBits+1)'(alloc_ok) - (RSIdxBits+1)'(handshake);
   assign cand_any     = |sel_grant;

   rs_age_select #(.IdxBits(RSIdxBits)) u_age_select (
      .req       (cand),
      .older     (age_q),
      .grant     (sel_grant),
      .grant_idx (sel_idx)
   );

   // New entry is younger than every entry that survives this cycle.
   always_comb begin
      age_d = age_q;
      if (alloc_ok) begin
         age_d[allocIdx_i] = '0;
         for (int i = 0; i < N; i++) begin
            age_d[i][allocIdx_i] = survivors[i];
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= SCHED_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_offer = 1'b0;
      if (flush_i) begin
         state_d = SCHED_IDLE;
      end else begin
         case (state_q)
            SCHED_IDLE: begin
               if (cand_any) begin
                  state_d    = SCHED_OFFER;
                  load_offer = 1'b1;
               end
            end
            SCHED_OFFER: begin
               if (handshake) begin
                  if (cand_any) begin
                     load_offer = 1'b1;
                  end else begin
                     state_d = SCHED_IDLE;
                  end
               end
            end
            default: state_d = SCHED_IDLE;
         endcase
      end
   end

   always_comb begin
      issue_valid = (state_q == SCHED_OFFER);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         occupied_q   <= '0;
         age_q        <= '0;
         issue_idx_q  <= '0;
         free_valid_q <= 1'b0;
         free_idx_q   <= '0;
         occupancy_q  <= '0;
      end else if (flush_i) begin
         occupied_q   <= '0;
         age_q        <= '0;
         issue_idx_q  <= '0;
         free_valid_q <= 1'b0;
         free_idx_q   <= '0;
         occupancy_q  <= '0;
      end else begin
         occupied_q   <= occupied_d;
         age_q        <= age_d;
         free_valid_q <= handshake;
         occupancy_q  <= occupancy_d;
         if (load_offer) begin
            issue_idx_q <= sel_idx;
         end
         if (handshake) begin
            free_idx_q <= issue_idx_q;
         end
      end
   end

   assign issueValid_o = issue_valid;
   assign issueIdx_o   = issue_idx_q;
   assign freeValid_o  = free_valid_q;
   assign freeIdx_o    = free_idx_q;
   assign occupancy_o  = occupancy_q;
   assign isFull_o     = (occupancy_q == (RSIdxBits+1)'(N));

`ifdef RS_ISSUE_STATS_EN
   logic [31:0] issue_count_q, stall_count_q;

   // Saturating counters survive flush; only reset clears them.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         issue_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (handshake && (issue_count_q != '1)) begin
            issue_count_q <= issue_count_q + 32'd1;
         end
         if (issue_valid && !fuReady_i && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign issueCount_o = issue_count_q;
   assign stallCount_o = stall_count_q;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - randomized bench with an allocation-order reference model
module tb_rs_issue_scheduler;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       flush_i;
   logic       allocValid_i;
   logic [2:0] allocIdx_i;
   logic [7:0] opReady_i;
   logic       fuReady_i;
   logic       issueValid_o;
   logic [2:0] issueIdx_o;
   logic       freeValid_o;
   logic [2:0] freeIdx_o;
   logic [3:0] occupancy_o;
   logic       isFull_o;
`ifdef RS_ISSUE_STATS_EN
   logic [31:0] issueCount_o;
   logic [31:0] stallCount_o;
`endif

   rs_issue_scheduler #(.RSIdxBits(3), .RStationInstance(0)) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .flush_i      (flush_i),
      .allocValid_i (allocValid_i),
      .allocIdx_i   (allocIdx_i),
      .opReady_i    (opReady_i),
      .fuReady_i    (fuReady_i),
      .issueValid_o (issueValid_o),
      .issueIdx_o   (issueIdx_o),
      .freeValid_o  (freeValid_o),
      .freeIdx_o    (freeIdx_o),
      .occupancy_o  (occupancy_o),
`ifdef RS_ISSUE_STATS_EN
      .issueCount_o (issueCount_o),
      .stallCount_o (stallCount_o),
`endif
      .isFull_o     (isFull_o)
   );

   always #5 clock_i = ~clock_i;

   int checks = 0;
   int errors = 0;

   // Reference: entries kept in allocation order, oldest at the front.
   int order[$];
   bit m_valid;
   int m_idx;
   bit m_free_valid;
   int m_free_idx;
   int m_issue_cnt;
   int m_stall_cnt;

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic bit in_order(input int e);
      foreach (order[k]) if (order[k] == e) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      order.delete();
      m_valid = 0; m_idx = 0; m_free_valid = 0; m_free_idx = 0;
      m_issue_cnt = 0; m_stall_cnt = 0;
   endtask

   task automatic model_step();
      bit hs;
      bit accept;
      int sel;
      int a;
      hs = m_valid && fuReady_i;
      if (hs) m_issue_cnt++;
      if (m_valid && !fuReady_i) m_stall_cnt++;
      if (flush_i) begin
         order.delete();
         m_valid = 0; m_idx = 0; m_free_valid = 0; m_free_idx = 0;
         return;
      end
      sel = -1;
      foreach (order[k]) begin
         if (sel < 0 && opReady_i[order[k]] && !(m_valid && order[k] == m_idx)) sel = order[k];
      end
      m_free_valid = hs;
      if (hs) m_free_idx = m_idx;
      a = int'(allocIdx_i);
      accept = allocValid_i && (!in_order(a) || (hs && a == m_idx));
      if (hs) begin
         for (int k = 0; k < order.size(); k++) begin
            if (order[k] == m_idx) begin
               order.delete(k);
               break;
            end
         end
      end
      if (accept) order.push_back(a);
      if (!m_valid) begin
         if (sel >= 0) begin m_valid = 1; m_idx = sel; end
      end else if (hs) begin
         if (sel >= 0) m_idx = sel;
         else m_valid = 0;
      end
   endtask

   task automatic check_all();
      chk("issue_valid", issueValid_o, m_valid);
      if (m_valid) chk("issue_idx", issueIdx_o, m_idx);
      chk("free_valid", freeValid_o, m_free_valid);
      if (m_free_valid) chk("free_idx", freeIdx_o, m_free_idx);
      chk("occupancy", occupancy_o, order.size());
      chk("is_full", isFull_o, order.size() == 8);
`ifdef RS_ISSUE_STATS_EN
      chk("issue_count", issueCount_o, m_issue_cnt);
      chk("stall_count", stallCount_o, m_stall_cnt);
`endif
   endtask

   task automatic tick();
      model_step();
      @(posedge clock_i);
      @(negedge clock_i);
      check_all();
   endtask

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; allocValid_i = 1'b0; allocIdx_i = '0;
      opReady_i = '0; fuReady_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clock_i);
      chk("rst_issue_valid", issueValid_o, 0);
      chk("rst_free_valid", freeValid_o, 0);
      chk("rst_occupancy", occupancy_o, 0);
      chk("rst_is_full", isFull_o, 0);
      reset_i = 1'b0;

      // Allocations 5,2,7 issue back to back in order
      opReady_i = 8'hFF; fuReady_i = 1'b1;
      allocValid_i = 1'b1; allocIdx_i = 3'd5; tick();
      chk("a_occ", occupancy_o, 1);
      chk("a_no_issue_yet", issueValid_o, 0);
      allocIdx_i = 3'd2; tick();
      chk("a_issue5", issueIdx_o, 5);
      allocIdx_i = 3'd7; tick();
      chk("a_issue2", issueIdx_o, 2);
      chk("a_free5", freeIdx_o, 5);
      allocValid_i = 1'b0; tick();
      chk("a_issue7", issueIdx_o, 7);
      chk("a_free2", freeIdx_o, 2);
      tick();
      chk("a_idle", issueValid_o, 0);
      chk("a_free7", freeIdx_o, 7);

      // Stalled offer holds even when its operands drop
      fuReady_i = 1'b0; allocValid_i = 1'b1; allocIdx_i = 3'd3; tick();
      allocValid_i = 1'b0; tick();
      chk("b_offer3", issueIdx_o, 3);
      opReady_i = 8'hF7;
      repeat (4) begin
         tick();
         chk("b_hold_valid", issueValid_o, 1);
         chk("b_hold_idx", issueIdx_o, 3);
      end
      fuReady_i = 1'b1; tick();
      chk("b_free3", freeIdx_o, 3);
      chk("b_done", issueValid_o, 0);
`ifdef RS_ISSUE_STATS_EN
      chk("b_stalls", stallCount_o, 4);
      chk("b_issues", issueCount_o, 4);
`endif
      fuReady_i = 1'b0;

      // Fill the station, then alloc into the slot freed the same cycle
      opReady_i = 8'h00; allocValid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         allocIdx_i = 3'(i); tick();
      end
      allocValid_i = 1'b0;
      chk("c_full", isFull_o, 1);
      chk("c_occ8", occupancy_o, 8);
      opReady_i = 8'hFF; tick();
      chk("c_offer0", issueIdx_o, 0);
      fuReady_i = 1'b1; allocValid_i = 1'b1; allocIdx_i = 3'd0; tick();
      chk("c_occ_stays8", occupancy_o, 8);
      chk("c_free0", freeIdx_o, 0);
      chk("c_offer1", issueIdx_o, 1);
      allocValid_i = 1'b0; tick(); tick();
      chk("c_occ6", occupancy_o, 6);

      // Flush with six occupied and an offer pending
      fuReady_i = 1'b0; flush_i = 1'b1; tick();
      chk("d_valid0", issueValid_o, 0);
      chk("d_idx0", issueIdx_o, 0);
      chk("d_free0", freeValid_o, 0);
      chk("d_occ0", occupancy_o, 0);
      flush_i = 1'b0; tick();
      chk("d_stays_idle", issueValid_o, 0);

      // Reallocating the issued index makes it youngest
      opReady_i = 8'h00; allocValid_i = 1'b1;
      allocIdx_i = 3'd4; tick();
      allocIdx_i = 3'd1; tick();
      allocIdx_i = 3'd6; tick();
      allocValid_i = 1'b0; opReady_i = 8'h10; tick();
      chk("e_offer4", issueIdx_o, 4);
      opReady_i = 8'hFF; fuReady_i = 1'b1; allocValid_i = 1'b1; allocIdx_i = 3'd4; tick();
      chk("e_free4", freeIdx_o, 4);
      chk("e_offer1", issueIdx_o, 1);
      allocValid_i = 1'b0; tick();
      chk("e_offer6", issueIdx_o, 6);
      tick();
      chk("e_offer4_last", issueIdx_o, 4);
      tick();
      chk("e_idle", issueValid_o, 0);

      // Asynchronous reset in the middle of an offer
      fuReady_i = 1'b0; allocValid_i = 1'b1; allocIdx_i = 3'd2; tick();
      allocValid_i = 1'b0; tick();
      chk("f_offer2", issueValid_o, 1);
      #2 reset_i = 1'b1;
      #1;
      chk("f_async_valid", issueValid_o, 0);
      chk("f_async_idx", issueIdx_o, 0);
      chk("f_async_occ", occupancy_o, 0);
      chk("f_async_free", freeValid_o, 0);
      model_reset();
      @(negedge clock_i);
      reset_i = 1'b0;
      check_all();

      // Random traffic
      repeat (3000) begin
         allocValid_i = ($urandom_range(0, 9) < 6);
         allocIdx_i   = 3'($urandom_range(0, 7));
         opReady_i    = 8'($urandom);
         fuReady_i    = ($urandom_range(0, 3) != 0);
         flush_i      = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 Parameter SHALL be: RSIdxBits, 3, entry index width; entry count N = 2**RSIdxBits, derived.
REQ-002 Parameter SHALL be: RStationInstance, 0, number of the owning reservation station.
REQ-003 Port SHALL be: clock_i  input  1  single clock, rising edge.
REQ-004 Port SHALL be: reset_i  input  1  asynchronous, active-high reset.
REQ-005 Port SHALL be: flush_i  input  1  discard all tracked entries.
REQ-006 Port SHALL be: allocValid_i  input  1  entry written into the station this cycle.
REQ-007 Port SHALL be: allocIdx_i  input  RSIdxBits  index of the allocated entry.
REQ-008 Port SHALL be: opReady_i  input  N  per-entry flag, all source operands available.
REQ-009 Port SHALL be: fuReady_i  input  1  functional unit accepts an issue this cycle.
REQ-010 Port SHALL be: issueValid_o  output  1  issue offered to the functional unit.
REQ-011 Port SHALL be: issueIdx_o  output  RSIdxBits  index of the offered entry.
REQ-012 Port SHALL be: freeValid_o  output  1  one-cycle pulse, entry released.
REQ-013 Port SHALL be: freeIdx_o  output  RSIdxBits  index of the released entry.
REQ-014 Port SHALL be: occupancy_o  output  RSIdxBits+1  count of occupied entries.
REQ-015 Port SHALL be: isFull_o  output  1  occupancy_o == N.

Function
REQ-016 Block SHALL hold an occupied bit per entry and an N x N age matrix; older[i][j]=1 means i was allocated before j.
REQ-017 On allocValid_i, occupied[allocIdx_i] SHALL set, its row clear, and its column set for every occupied entry, making it youngest.
REQ-018 Alloc to an occupied index that is not being freed the same cycle SHALL be ignored with no state change.
REQ-019 Candidates SHALL be occupied & opReady_i & not currently offered; selection SHALL be the candidate with no older candidate.
REQ-020 FSM SHALL have states IDLE and OFFER; IDLE with a candidate at cycle t SHALL give issueValid_o=1 with the registered index at t+1, entering OFFER.
REQ-021 In OFFER with fuReady_i=0, issueValid_o and issueIdx_o SHALL hold stable; an offer SHALL never be withdrawn, even if opReady_i drops.
REQ-022 Handshake (issueValid_o & fuReady_i) SHALL clear occupied[issueIdx_o] and give freeValid_o=1, freeIdx_o=issued index, next cycle.
REQ-023 On handshake the next-oldest remaining candidate SHALL be offered next cycle (stay OFFER), else go IDLE; throughput one issue per cycle.
REQ-024 An entry allocated at cycle t SHALL not be a candidate before cycle t+1.
REQ-025 Alloc to the index freed by the same-cycle handshake SHALL win: entry stays occupied, becomes youngest, freeValid_o still pulses.
REQ-026 occupancy_o SHALL update registered as +alloc -handshake; simultaneous alloc and handshake SHALL leave it unchanged.
REQ-027 flush_i SHALL, at the next edge, clear occupied, age matrix, issueValid_o, freeValid_o, occupancy_o, and go IDLE, overriding same-cycle alloc and handshake; no freeValid_o pulse for flushed entries.

Reset
REQ-028 reset_i high SHALL immediately force all outputs to 0, FSM to IDLE, occupied bits and age matrix to 0.
REQ-029 First issue after reset release SHALL need an allocation plus one cycle per REQ-020/024.

Configuration
REQ-030 Macro RS_ISSUE_STATS_EN defined SHALL add outputs issueCount_o and stallCount_o (32 bits each).
REQ-031 issueCount_o SHALL count handshakes; stallCount_o SHALL count cycles with issueValid_o & !fuReady_i; both saturate at all-ones, cleared only by reset.
REQ-032 Without RS_ISSUE_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold FSM state encoding (SCHED_IDLE, SCHED_OFFER) and the RSIdxBits default.
REQ-034 Oldest-of-set selection SHALL be a combinational sub-module rs_age_select (request vector plus age matrix in, one-hot grant plus index out).

Verification (RSIdxBits=3)
REQ-035 Alloc 5,2,7 on cycles 0-2, opReady_i=8'hFF, fuReady_i=1 -> issueIdx_o 5,2,7 on consecutive cycles; freeIdx_o follows one cycle later.
REQ-036 Offer idx 3 with fuReady_i=0 for 4 cycles, opReady_i[3] dropped -> issueIdx_o holds 3, then one handshake; stallCount_o=4 with RS_ISSUE_STATS_EN.
REQ-037 Allocate all 8 entries -> isFull_o=1, occupancy_o=8; alloc plus handshake same cycle -> occupancy_o stays 8.
REQ-038 Handshake on idx 4 with allocIdx_i=4 same cycle -> freeValid_o pulse for 4, entry 4 reoccupied as youngest, issued after older ready entries.
REQ-039 flush_i with 6 occupied and an offer pending -> next cycle all outputs 0, no free pulse; reset_i asserted mid-OFFER -> outputs 0 immediately, before the next clock edge.
